board_cursor_ctrl: RTL and testbench

//  Upstream stage of the drawcon/vga_out pixel path. Turns four push-buttons into a grid-aligned

---
 rtl/board_pkg.sv | 40 ++++
 rtl/btn_sync.sv | 29 ++
 rtl/board_cursor_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_board_cursor_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Shared board geometry, scan timing and cursor enums for the drawcon pixel path.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package board_pkg;

  localparam int H_ACTIVE     = 1280;
  localparam int V_ACTIVE     = 800;
  localparam int ORIGIN_X     = 80;
  localparam int ORIGIN_Y     = 0;
  localparam int CELL_W       = 140;
  localparam int CELL_H       = 100;
  localparam int COLS         = 8;
  localparam int ROWS         = 8;
  localparam int REPEAT_DELAY = 20;
  localparam int REPEAT_RATE  = 6;

  typedef enum logic [2:0] {
    DIR_NONE,
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } dir_e;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } cursor_state_e;

  // Fixed-priority decode of {up, down, left, right}; opposite pairs resolve to the higher one.
  function automatic dir_e decode_dir(input logic [3:0] btn);
    if (btn[3]) return DIR_UP;
    else if (btn[2]) return DIR_DOWN;
    else if (btn[1]) return DIR_LEFT;
    else if (btn[0]) return DIR_RIGHT;
    else return DIR_NONE;
  endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchroniser for raw asynchronous push-buttons.
// Latency: 2 clk cycles.
// Backpressure: none; free-running.
module btn_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Metastability chain: first stage may go metastable, second stage is clean.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/board_cursor_ctrl.sv
// Push-button driven, grid-aligned board cursor; buttons sampled once per frame with auto-repeat.
// Latency: pos/col/row/moved update the cycle after frame_tick; frame_tick 1 cycle after scan hit.
// Backpressure: none; unsampled button activity between frame ticks is ignored.
module board_cursor_ctrl
  import board_pkg::*;
#(
  parameter int P_V_ACTIVE     = V_ACTIVE,
  parameter int P_ORIGIN_X     = ORIGIN_X,
  parameter int P_ORIGIN_Y     = ORIGIN_Y,
  parameter int P_CELL_W       = CELL_W,
  parameter int P_CELL_H       = CELL_H,
  parameter int P_COLS         = COLS,
  parameter int P_ROWS         = ROWS,
  parameter int P_REPEAT_DELAY = REPEAT_DELAY,
  parameter int P_REPEAT_RATE  = REPEAT_RATE
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        btn_up,
  input  logic                        btn_down,
  input  logic                        btn_left,
  input  logic                        btn_right,
  input  logic [10:0]                 curr_x,
  input  logic [9:0]                  curr_y,
  output logic [10:0]                 pos_x,
  output logic [9:0]                  pos_y,
  output logic [$clog2(P_COLS)-1:0]   col,
  output logic [$clog2(P_ROWS)-1:0]   row,
  output logic                        frame_tick,
  output logic                        moved
);

  localparam int CW      = $clog2(P_COLS);
  localparam int RW      = $clog2(P_ROWS);
  localparam int CNT_MAX = (P_REPEAT_DELAY > P_REPEAT_RATE) ? P_REPEAT_DELAY : P_REPEAT_RATE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0]    COL_LAST    = CW'(P_COLS - 1);
  localparam logic [RW-1:0]    ROW_LAST    = RW'(P_ROWS - 1);
  localparam logic [10:0]      X0          = 11'(P_ORIGIN_X);
  localparam logic [9:0]       Y0          = 10'(P_ORIGIN_Y);
  localparam logic [10:0]      DX          = 11'(P_CELL_W);
  localparam logic [9:0]       DY          = 10'(P_CELL_H);
  localparam logic [9:0]       TICK_LINE   = 10'(P_V_ACTIVE);
  localparam logic [CNT_W-1:0] RELOAD_DLY  = CNT_W'(P_REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RELOAD_RATE = CNT_W'(P_REPEAT_RATE - 1);

  logic [3:0]    w_btn_sync;
  dir_e          w_dir;

  logic          r_frame_tick;
  cursor_state_e r_state;
  cursor_state_e w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  dir_e          r_last_dir;
  dir_e          w_last_nxt;
  logic          w_step_req;
  logic          w_blocked;
  logic          w_do_move;

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [10:0]   r_pos_x;
  logic [9:0]    r_pos_y;
  logic          r_moved;

  btn_sync #(.WIDTH(4)) u_btn_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async ({btn_up, btn_down, btn_left, btn_right}),
    .o_sync  (w_btn_sync)
  );

  assign w_dir = decode_dir(w_btn_sync);

  // Frame tick: one pulse per frame, the cycle after the scan reaches the first blanking line.
  always_ff @(posedge clk) begin
    if (!rst_n) r_frame_tick <= 1'b0;
    else        r_frame_tick <= (curr_x == 11'd0) && (curr_y == TICK_LINE);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; the FSM only advances on frame ticks.
  always_comb begin
    w_state_nxt = r_state;
    if (r_frame_tick) begin
      case (r_state)
        IDLE: begin
          if (w_dir != DIR_NONE) w_state_nxt = DELAY;
        end
        DELAY: begin
          if (w_dir == DIR_NONE)            w_state_nxt = IDLE;
          else if (w_dir != r_last_dir)     w_state_nxt = DELAY;
          else if (r_cnt == '0)             w_state_nxt = REPEAT;
        end
        REPEAT: begin
          if (w_dir == DIR_NONE)            w_state_nxt = IDLE;
          else if (w_dir != r_last_dir)     w_state_nxt = DELAY;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Output logic: step request, repeat counter and last-direction updates.
  always_comb begin
    w_step_req = 1'b0;
    w_cnt_nxt  = r_cnt;
    w_last_nxt = r_last_dir;
    if (r_frame_tick) begin
      case (r_state)
        IDLE: begin
          if (w_dir != DIR_NONE) begin
            w_step_req = 1'b1;
            w_last_nxt = w_dir;
            w_cnt_nxt  = RELOAD_DLY;
          end
        end
        DELAY, REPEAT: begin
          if (w_dir == DIR_NONE) begin
            w_last_nxt = DIR_NONE;
            w_cnt_nxt  = '0;
          end else if (w_dir != r_last_dir) begin
            w_step_req = 1'b1;
            w_last_nxt = w_dir;
            w_cnt_nxt  = RELOAD_DLY;
          end else if (r_cnt == '0) begin
            w_step_req = 1'b1;
            w_cnt_nxt  = RELOAD_RATE;
          end else begin
            w_cnt_nxt  = r_cnt - CNT_W'(1);
          end
        end
        default: begin
          w_last_nxt = DIR_NONE;
          w_cnt_nxt  = '0;
        end
      endcase
    end
  end

  // Repeat counter and last accepted direction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_last_dir <= DIR_NONE;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_last_dir <= w_last_nxt;
    end
  end

  // Edge blocking: a step that would leave the board is dropped (no wrap).
  always_comb begin
    w_blocked = 1'b1;
    case (w_dir)
      DIR_UP:    w_blocked = (r_row == '0);
      DIR_DOWN:  w_blocked = (r_row == ROW_LAST);
      DIR_LEFT:  w_blocked = (r_col == '0);
      DIR_RIGHT: w_blocked = (r_col == COL_LAST);
      default:   w_blocked = 1'b1;
    endcase
  end

  assign w_do_move = w_step_req && !w_blocked;

  // Cell and pixel position move together so pos stays ORIGIN + index*CELL without a multiplier.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_col   <= '0;
      r_row   <= '0;
      r_pos_x <= X0;
      r_pos_y <= Y0;
      r_moved <= 1'b0;
    end else begin
      r_moved <= w_do_move;
      if (w_do_move) begin
        case (w_dir)
          DIR_UP: begin
            r_row   <= r_row - RW'(1);
            r_pos_y <= r_pos_y - DY;
          end
          DIR_DOWN: begin
            r_row   <= r_row + RW'(1);
            r_pos_y <= r_pos_y + DY;
          end
          DIR_LEFT: begin
            r_col   <= r_col - CW'(1);
            r_pos_x <= r_pos_x - DX;
          end
          DIR_RIGHT: begin
            r_col   <= r_col + CW'(1);
            r_pos_x <= r_pos_x + DX;
          end
          default: ;
        endcase
      end
    end
  end

  assign col        = r_col;
  assign row        = r_row;
  assign pos_x      = r_pos_x;
  assign pos_y      = r_pos_y;
  assign moved      = r_moved;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_board_cursor_ctrl.sv
// Directed bench for board_cursor_ctrl with a per-frame reference model feeding a scoreboard.
// Frames are compressed: the scan position is driven straight to the tick point each frame.
// Expected results are pushed when a frame's buttons are driven and popped after the tick.
module tb_board_cursor_ctrl;
  import board_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        b_up, b_down, b_left, b_right;
  logic [10:0] curr_x;
  logic [9:0]  curr_y;
  logic [10:0] pos_x;
  logic [9:0]  pos_y;
  logic [2:0]  col;
  logic [2:0]  row;
  logic        frame_tick;
  logic        moved;

  always #5 clk = ~clk;

  board_cursor_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_up     (b_up),
    .btn_down   (b_down),
    .btn_left   (b_left),
    .btn_right  (b_right),
    .curr_x     (curr_x),
    .curr_y     (curr_y),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .col        (col),
    .row        (row),
    .frame_tick (frame_tick),
    .moved      (moved)
  );

  typedef struct {
    int col;
    int row;
    int px;
    int py;
    int mv;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: hold-count formulation (step on first frame, then at DELAY, DELAY+RATE, ...).
  int m_col, m_row, m_n, m_last;

  localparam logic [3:0] B_NONE  = 4'b0000;
  localparam logic [3:0] B_UP    = 4'b1000;
  localparam logic [3:0] B_DOWN  = 4'b0100;
  localparam logic [3:0] B_LEFT  = 4'b0010;
  localparam logic [3:0] B_RIGHT = 4'b0001;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int prio(input logic [3:0] b);
    if (b[3]) return 1;
    if (b[2]) return 2;
    if (b[1]) return 3;
    if (b[0]) return 4;
    return 0;
  endfunction

  task automatic model_reset();
    m_col = 0; m_row = 0; m_n = 0; m_last = 0;
  endtask

  task automatic model_frame(input int d);
    exp_t e;
    bit   step;
    int   mv;
    mv = 0;
    if (d == 0) begin
      m_last = 0; m_n = 0; step = 0;
    end else if (d != m_last) begin
      m_last = d; m_n = 0; step = 1;
    end else begin
      m_n++;
      step = (m_n >= REPEAT_DELAY) && (((m_n - REPEAT_DELAY) % REPEAT_RATE) == 0);
    end
    if (step) begin
      case (d)
        1: if (m_row > 0)        begin m_row--; mv = 1; end
        2: if (m_row < ROWS - 1) begin m_row++; mv = 1; end
        3: if (m_col > 0)        begin m_col--; mv = 1; end
        4: if (m_col < COLS - 1) begin m_col++; mv = 1; end
        default: ;
      endcase
    end
    e.col = m_col;
    e.row = m_row;
    e.px  = ORIGIN_X + m_col * CELL_W;
    e.py  = ORIGIN_Y + m_row * CELL_H;
    e.mv  = mv;
    sb.push_back(e);
  endtask

  // One compressed frame: drive buttons, let them synchronise, hit the tick point, check.
  task automatic frame(input logic [3:0] b);
    exp_t e;
    @(negedge clk);
    {b_up, b_down, b_left, b_right} = b;
    curr_x = 11'd17;
    curr_y = 10'd300;
    model_frame(prio(b));
    repeat (3) @(negedge clk);
    curr_x = 11'd0;
    curr_y = 10'(V_ACTIVE);
    @(negedge clk);
    curr_x = 11'd1;
    check("frame_tick_hi", 32'(frame_tick), 1);
    @(negedge clk);
    check("frame_tick_lo", 32'(frame_tick), 0);
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      check("col",   32'(col),   e.col);
      check("row",   32'(row),   e.row);
      check("pos_x", 32'(pos_x), e.px);
      check("pos_y", 32'(pos_y), e.py);
      check("moved", 32'(moved), e.mv);
      @(negedge clk);
      check("moved_pulse_end", 32'(moved), 0);
      check("col_stable",      32'(col),   e.col);
      check("row_stable",      32'(row),   e.row);
    end
  endtask

  task automatic hold(input logic [3:0] b, input int n);
    for (int i = 0; i < n; i++) frame(b);
  endtask

  task automatic check_home(input string tag);
    check({tag, "_col"},   32'(col),   0);
    check({tag, "_row"},   32'(row),   0);
    check({tag, "_pos_x"}, 32'(pos_x), 80);
    check({tag, "_pos_y"}, 32'(pos_y), 0);
    check({tag, "_moved"}, 32'(moved), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    {b_up, b_down, b_left, b_right} = B_NONE;
    curr_x = 11'd5;
    curr_y = 10'd5;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    check_home("reset");
    check("reset_frame_tick", 32'(frame_tick), 0);

    // Idle frames: nothing moves.
    hold(B_NONE, 2);

    // Single right tap.
    frame(B_RIGHT);
    frame(B_NONE);
    check("tap_right_col", 32'(col), 1);
    check("tap_right_px",  32'(pos_x), 220);

    // Up at row 0 is blocked; left to col 0, then held left is blocked.
    frame(B_UP);
    frame(B_NONE);
    frame(B_LEFT);
    frame(B_NONE);
    hold(B_LEFT, 25);
    frame(B_NONE);
    check("left_edge_col", 32'(col), 0);

    // Held down for 40 frames: steps at 0, 20, 26, 32, 38.
    hold(B_DOWN, 40);
    frame(B_NONE);
    check("hold_down_row", 32'(row), 5);
    check("hold_down_py",  32'(pos_y), 500);

    // Held right for 60 frames saturates at the last column.
    hold(B_RIGHT, 60);
    frame(B_NONE);
    check("sat_col", 32'(col), 7);
    check("sat_px",  32'(pos_x), 1060);

    // Move to (3,3).
    for (int i = 0; i < 4; i++) begin frame(B_LEFT); frame(B_NONE); end
    for (int i = 0; i < 2; i++) begin frame(B_UP);   frame(B_NONE); end
    check("pre_combo_col", 32'(col), 3);
    check("pre_combo_row", 32'(row), 3);

    // Up+right: priority picks up. Then right alone mid-DELAY steps at once and restarts the delay.
    hold(B_UP | B_RIGHT, 5);
    check("combo_col", 32'(col), 3);
    check("combo_row", 32'(row), 2);
    hold(B_RIGHT, 21);
    frame(B_NONE);
    check("restart_col", 32'(col), 5);

    // Reach (5,5) in REPEAT, then pulse reset mid-hold.
    hold(B_DOWN, 28);
    check("repeat_col", 32'(col), 5);
    check("repeat_row", 32'(row), 5);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check_home("midhold_reset");
    frame(B_DOWN);
    check("post_reset_row", 32'(row), 1);
    frame(B_NONE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
